arb_mux_n: RTL and testbench
============================

# arb_mux_n

Parametrised N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the team's one-hot-select universal mux. Channel selection is no longer driven by an external one-hot select: an internal arbiter generates it, using either fixed-priority or round-robin mode. The selected word passes through a registered output stage. The block sits between several producer channels and a single downstream consumer.

## Interface
- `N_CH`, 8: number of input channels; legal values 2..32.
- `DATA_W`, 8: width of each data word.
- `MODE`, `ARB_RR`: arbitration mode, of type `arb_mode_e`.
  - `ARB_FIXED`: lowest index wins.
  - `ARB_RR`: round-robin.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in [N_CH]: per-channel request.
- `in_data` in [N_CH][DATA_W]: per-channel data word.
- `in_ready` out [N_CH]: per-channel accept; at most one bit set.
- `out_valid` out 1: output register holds a word.
- `out_data` out DATA_W: registered data.
- `out_ready` in 1: consumer accepts the word.
- `out_grant` out [N_CH]: one-hot channel that sourced `out_data`.
- `out_ch` out $clog2(N_CH): binary index of `out_grant`.

## Operation
- **Load condition:** `load = !out_valid || out_ready`.
  - The output register accepts a new word only when `load` is high.
- **Arbitration:** combinational over `in_valid`.
  - The result is a one-hot `gnt`, all-zero if no request is pending.
- **Accept:** `in_ready = gnt & {N_CH{load}}`.
  - A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- **Update on `load`:**
  - `out_valid <= |gnt`.
  - If `|gnt`: `out_data <= in_data[idx(gnt)]`, `out_grant <= gnt`, `out_ch <= idx(gnt)`.
  - If no grant, `out_data`, `out_grant` and `out_ch` hold their values.
- **`ARB_FIXED`:** the lowest asserted index wins. The pointer is unused.
- **`ARB_RR`:**
  - The pointer `ptr` (width $clog2(N_CH)) marks the highest-priority channel.
  - The search runs `ptr`, `ptr+1`, … modulo N_CH.
  - After a transfer on channel g: `ptr <= (g+1) mod N_CH`. The wrap from N_CH-1 goes to 0.
  - `ptr` is unchanged when there is no transfer.
- **Stall:** `out_valid && !out_ready`.
  - `out_data`, `out_grant` and `out_ch` are held stable.
  - All `in_ready` bits are 0.
  - `ptr` is held.
- **Input rule:** once asserted, producers must hold `in_valid` and `in_data` until accepted. The block does not check this.
- **Gapless streaming:** a simultaneous output consume and new load is legal and gives back-to-back words.
- **No requests:** when `load` is high and no channel requests, `out_valid` falls to 0.

## Timing
- **Reset values** (`rst` high at a clock edge):
  - `out_valid=0`, `out_data=0`, `out_grant=0`, `out_ch=0`, `ptr=0`.
  - `in_ready` is all 0 while `rst` is high.
- **Latency:** 1 cycle from input accept to `out_valid`.
- **Throughput:** 1 word per cycle when `out_ready` is held high.
- **Reset mid-operation:** the word in the output register is discarded, with no handshake completed. Arbitration restarts from channel 0.
- **Round-robin fairness:** with all N_CH channels continuously requesting, each channel is granted exactly once every N_CH transfers.
- **Combinational paths:**
  - `out_ready` → `in_ready` (via `load`).
  - `in_valid` → `in_ready`.
  - There is no path from any input to `out_*`.

## Structure
- **Shared package `arb_mux_pkg`** contains:
  - `typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e`.
  - Function `onehot2idx`.
  - Constant `MAX_CH = 32`.
- **Sub-module `rr_arbiter`** (params `N_CH`, `MODE`; ports `clk`, `rst`, `req`, `advance`, `gnt`):
  - Holds `ptr`.
  - Masked-priority implementation: a masked request vector, then an unmasked fallback.
- **Top `arb_mux_n`:** contains the load logic, output register, and one-hot-to-index data mux.

## Test plan
Default parameters; inputs `in_data = {aa, bb, cc, dd, ee, ff, 11, 22}` (hex).
1. **Reset:** assert `rst` for 2 cycles with all `in_valid=1`.
   - All outputs are 0 and `in_ready=0`.
   - First cycle after release: `in_ready=00000001`.
   - Next cycle: `out_data=aa`, `out_ch=0`.
2. **Round-robin fairness:** all 8 channels valid, `out_ready=1`, MODE=`ARB_RR`.
   - Output sequence is aa, bb, cc, dd, ee, ff, 11, 22, then aa again (wrap).
   - One word per cycle.
3. **Fixed priority:** MODE=`ARB_FIXED`, channels 2 and 5 valid, `out_ready=1`.
   - Output is cc, cc, … and channel 5 is never granted while channel 2 stays valid.
   - Drop channel 2: output becomes ff.
4. **Backpressure:** `out_ready=0` for 4 cycles with `out_valid=1`, `out_data=dd`.
   - `out_data`, `out_grant=00001000` and `out_ch=3` are held stable.
   - `in_ready` is 0 for all 4 cycles.
   - Raise `out_ready`: the next grant follows channel 3, e.g. channel 5 if only 1 and 5 request.
5. **Sparse requests and wrap:** only channels 7 and 0 valid, MODE=`ARB_RR`.
   - Output alternates 22, aa, 22, aa.
   - `ptr` wraps 0 → 1 → 0 correctly.
   - Then drop all requests: `out_valid` falls to 0 after the last consume.
6. **Reset during stall:** pulse `rst` while `out_valid=1` and `out_ready=0`.
   - `out_valid=0` on the next cycle and the word is lost.
   - The next grant goes to channel 0.
   - Repeat scenario 2 with `N_CH=3`, `DATA_W=16` and check the 3-channel rotation.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared types, limits and helpers for the arbitrating mux
//
// Contents:
//   MAX_CH      largest supported channel count
//   arb_mode_e  arbitration mode (ARB_FIXED: lowest index wins, ARB_RR: round-robin)
//   onehot2idx  binary index of a one-hot vector (all-zero input gives 0)
package arb_mux_pkg;

  localparam int MAX_CH = 32;
  localparam int MAX_IDX_W = $clog2(MAX_CH);

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_CH-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - fixed-priority / round-robin arbiter with priority pointer
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (pointer back to channel 0)
//   req      per-channel request vector
//   advance  a transfer happened on the currently granted channel this cycle
//   gnt      one-hot grant, all-zero when nothing requests
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int        N_CH = 8,
  parameter arb_mode_e MODE = ARB_RR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] gnt
);

  localparam int IDX_W = $clog2(N_CH);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W-1:0] w_ptr_next;
  logic [N_CH-1:0]  w_mask;
  logic [N_CH-1:0]  w_masked;
  logic [N_CH-1:0]  w_masked_low;
  logic [N_CH-1:0]  w_req_low;

  // Channels at or above the pointer keep priority; the rest only win
  // through the unmasked fallback, which gives the wrap-around order.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_mask[i] = (i >= int'(r_ptr));
    end
  end

  assign w_masked     = req & w_mask;
  // x & -x isolates the lowest set bit.
  assign w_masked_low = w_masked & (-w_masked);
  assign w_req_low    = req & (-req);

  always_comb begin
    gnt = w_req_low;
    if (MODE == ARB_RR && (|w_masked)) gnt = w_masked_low;
  end

  assign w_gnt_idx  = IDX_W'(onehot2idx(MAX_CH'(gnt)));
  assign w_ptr_next = (int'(w_gnt_idx) == N_CH - 1) ? '0 : w_gnt_idx + IDX_W'(1);

  // In fixed mode the pointer still tracks grants but never affects gnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - N-channel arbitrating multiplexer with registered output
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   per-channel request
//   in_data    per-channel data word (in_data[i] belongs to channel i)
//   in_ready   per-channel accept, at most one bit set
//   out_valid  output register holds a word
//   out_data   registered data word
//   out_ready  consumer accepts the word
//   out_grant  one-hot channel that sourced out_data
//   out_ch     binary index of out_grant
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int        N_CH   = 8,
  parameter int        DATA_W = 8,
  parameter arb_mode_e MODE   = ARB_RR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               in_valid,
  input  logic [N_CH-1:0][DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]               in_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic [N_CH-1:0]               out_grant,
  output logic [$clog2(N_CH)-1:0]       out_ch
);

  localparam int IDX_W = $clog2(N_CH);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [N_CH-1:0]   r_out_grant;
  logic [IDX_W-1:0]  r_out_ch;

  logic              w_load;
  logic              w_accept;
  logic [N_CH-1:0]   w_gnt;
  logic [IDX_W-1:0]  w_idx;

  // The register can take a word when empty or being drained this cycle.
  assign w_load   = !r_out_valid || out_ready;
  // Nothing is accepted while reset is asserted, so no word is lost upstream.
  assign w_accept = w_load && !rst;
  assign in_ready = w_gnt & {N_CH{w_accept}};

  rr_arbiter #(
    .N_CH (N_CH),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (|in_ready),
    .gnt     (w_gnt)
  );

  assign w_idx = IDX_W'(onehot2idx(MAX_CH'(w_gnt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_grant <= '0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      r_out_valid <= |w_gnt;
      // Payload holds its last value when the register empties.
      if (|w_gnt) begin
        r_out_data  <= in_data[w_idx];
        r_out_grant <= w_gnt;
        r_out_ch    <= w_idx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_grant = r_out_grant;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - directed self-checking bench for arb_mux_n
module tb_arb_mux_n;
  import arb_mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-channel round-robin instance
  logic [7:0]      rr_valid = '0;
  logic [7:0][7:0] rr_data;
  logic [7:0]      rr_ready;
  logic            rr_ovalid;
  logic [7:0]      rr_odata;
  logic            rr_oready = 1'b1;
  logic [7:0]      rr_grant;
  logic [2:0]      rr_ch;

  // 8-channel fixed-priority instance
  logic [7:0]      fx_valid = '0;
  logic [7:0]      fx_ready;
  logic            fx_ovalid;
  logic [7:0]      fx_odata;
  logic            fx_oready = 1'b1;
  logic [7:0]      fx_grant;
  logic [2:0]      fx_ch;

  // 3-channel, 16-bit round-robin instance
  logic [2:0]       d3_valid = '0;
  logic [2:0][15:0] d3_data;
  logic [2:0]       d3_ready;
  logic             d3_ovalid;
  logic [15:0]      d3_odata;
  logic             d3_oready = 1'b1;
  logic [2:0]       d3_grant;
  logic [1:0]       d3_ch;

  logic [7:0] exp_tbl [8] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff, 8'h11, 8'h22};
  logic [15:0] exp3 [3] = '{16'ha001, 16'hb002, 16'hc003};

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    for (int i = 0; i < 8; i++) rr_data[i] = exp_tbl[i];
    for (int i = 0; i < 3; i++) d3_data[i] = exp3[i];
  end

  arb_mux_n #(.N_CH(8), .DATA_W(8), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_ready),
    .out_valid(rr_ovalid), .out_data(rr_odata), .out_ready(rr_oready),
    .out_grant(rr_grant), .out_ch(rr_ch)
  );

  arb_mux_n #(.N_CH(8), .DATA_W(8), .MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(fx_valid), .in_data(rr_data), .in_ready(fx_ready),
    .out_valid(fx_ovalid), .out_data(fx_odata), .out_ready(fx_oready),
    .out_grant(fx_grant), .out_ch(fx_ch)
  );

  arb_mux_n #(.N_CH(3), .DATA_W(16), .MODE(ARB_RR)) dut_3 (
    .clk(clk), .rst(rst), .in_valid(d3_valid), .in_data(d3_data), .in_ready(d3_ready),
    .out_valid(d3_ovalid), .out_data(d3_odata), .out_ready(d3_oready),
    .out_grant(d3_grant), .out_ch(d3_ch)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every channel requesting
    rst = 1'b1; rr_valid = 8'hff; rr_oready = 1'b1;
    tick(); tick();
    chk("rst_ovalid", 32'(rr_ovalid), 32'h0);
    chk("rst_odata",  32'(rr_odata),  32'h0);
    chk("rst_grant",  32'(rr_grant),  32'h0);
    chk("rst_ch",     32'(rr_ch),     32'h0);
    chk("rst_ready",  32'(rr_ready),  32'h0);
    rst = 1'b0; #1;
    chk("rel_ready", 32'(rr_ready), 32'h01);
    tick();
    chk("first_data", 32'(rr_odata), 32'haa);
    chk("first_ch",   32'(rr_ch),    32'h0);

    // Round-robin fairness with wrap
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rr_valid", 32'(rr_ovalid), 32'h1);
      chk("rr_data",  32'(rr_odata),  32'(exp_tbl[k % 8]));
      chk("rr_grant", 32'(rr_grant),  32'h1 << (k % 8));
    end

    // Backpressure: reach dd on channel 3, then stall
    tick(); tick(); tick();
    chk("bp_pre_data", 32'(rr_odata), 32'hdd);
    rr_oready = 1'b0; rr_valid = 8'h22; #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_data",  32'(rr_odata),  32'hdd);
      chk("bp_grant", 32'(rr_grant),  32'h08);
      chk("bp_ch",    32'(rr_ch),     32'h3);
      chk("bp_ready", 32'(rr_ready),  32'h00);
      tick();
    end
    rr_oready = 1'b1; #1;
    chk("bp_rel_ready", 32'(rr_ready), 32'h20);
    tick();
    chk("bp_next_data", 32'(rr_odata), 32'hff);
    chk("bp_next_ch",   32'(rr_ch),    32'h5);

    // Sparse requests on channels 7 and 0 (pointer now 6)
    rr_valid = 8'h81; #1;
    for (int k = 0; k < 4; k++) begin
      chk("sp_ready", 32'(rr_ready), (k % 2 == 0) ? 32'h80 : 32'h01);
      tick();
      chk("sp_data", 32'(rr_odata), (k % 2 == 0) ? 32'h22 : 32'haa);
    end
    rr_valid = 8'h00;
    tick();
    chk("idle_ovalid", 32'(rr_ovalid), 32'h0);
    chk("idle_hold",   32'(rr_odata),  32'haa);

    // Reset during a stall discards the word
    rr_valid = 8'h10;
    tick();
    chk("st_data", 32'(rr_odata), 32'hee);
    rr_oready = 1'b0; rr_valid = 8'hff;
    tick();
    chk("st_hold", 32'(rr_odata), 32'hee);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("st_rst_ovalid", 32'(rr_ovalid), 32'h0);
    chk("st_rst_ready",  32'(rr_ready),  32'h01);
    tick();
    chk("st_after_data", 32'(rr_odata), 32'haa);
    chk("st_after_ch",   32'(rr_ch),    32'h0);

    // Fixed priority: channels 2 and 5
    fx_valid = 8'h24; fx_oready = 1'b1; #1;
    chk("fx_ready", 32'(fx_ready), 32'h04);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fx_data",  32'(fx_odata), 32'hcc);
      chk("fx_grant", 32'(fx_grant), 32'h04);
    end
    fx_valid = 8'h20; #1;
    chk("fx_ready5", 32'(fx_ready), 32'h20);
    tick();
    chk("fx_data5", 32'(fx_odata), 32'hff);
    chk("fx_ch5",   32'(fx_ch),    32'h5);

    // 3-channel rotation
    d3_valid = 3'b111; d3_oready = 1'b1; #1;
    chk("d3_ready", 32'(d3_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("d3_data", 32'(d3_odata), 32'(exp3[k % 3]));
      chk("d3_ch",   32'(d3_ch),    32'(k % 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
